fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch.sv | 139 +++++++++++++
 tb/tb_fetch_prefetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: issues in-order fetch requests under a credit limit, buffers
// responses with their PCs in a small queue toward decode, and flushes/discards on redirect.
module fetch_prefetch #(
  parameter int                ADDR_W   = 64,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                STEP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_F,
  input  logic [ADDR_W-1:0] redirect_addr_F,
  output logic              imem_req_valid_F,
  input  logic              imem_req_ready_F,
  output logic [ADDR_W-1:0] imem_addr_F,
  input  logic              imem_rsp_valid_F,
  input  logic [INST_W-1:0] imem_rsp_data_F,
  output logic              inst_valid_D,
  input  logic              inst_ready_D,
  output logic [INST_W-1:0] inst_D,
  output logic [ADDR_W-1:0] pc_D
);

  localparam int                PW         = $clog2(DEPTH);
  localparam int                CW         = $clog2(DEPTH + 1);
  localparam logic [PW-1:0]     PTR_ONE    = PW'(1'b1);
  localparam logic [PW-1:0]     PTR_ZERO   = PW'(1'b0);
  localparam logic [CW-1:0]     CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0]     CNT_ZERO   = CW'(1'b0);
  localparam logic [CW:0]       CREDIT     = (CW + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP_V - ADDR_W'(1'b1));

  logic [ADDR_W-1:0] fpc_r;
  logic [INST_W-1:0] q_inst_r [DEPTH];
  logic [ADDR_W-1:0] q_pc_r   [DEPTH];
  logic [ADDR_W-1:0] o_pc_r   [DEPTH];
  logic [PW-1:0]     q_rd_r, q_wr_r, o_rd_r, o_wr_r;
  logic [CW-1:0]     q_cnt_r, o_cnt_r, disc_r;

  logic              issue_s, drop_s, push_s, pop_s;
  logic [CW-1:0]     o_cnt_nxt_s, q_left_s, q_cnt_nxt_s;
  logic [PW-1:0]     q_rd_nxt_s;
  logic [ADDR_W-1:0] rsp_pc_s, head_pc_s;
  logic [INST_W-1:0] head_inst_s;

  // Credit counts both buffered and in-flight instructions, so a push never finds the queue full.
  assign imem_req_valid_F = ({1'b0, q_cnt_r} + {1'b0, o_cnt_r}) < CREDIT;
  assign imem_addr_F      = fpc_r;
  assign issue_s          = imem_req_valid_F && imem_req_ready_F;
  assign drop_s           = imem_rsp_valid_F && (disc_r != CNT_ZERO);
  assign push_s           = imem_rsp_valid_F && !drop_s && !redirect_F;
  assign pop_s            = inst_valid_D && inst_ready_D && !redirect_F;
  assign rsp_pc_s         = o_pc_r[o_rd_r];

  // Next-state counts and the entry that becomes the decode head after this edge.
  always_comb begin
    o_cnt_nxt_s = o_cnt_r;
    case ({issue_s, imem_rsp_valid_F})
      2'b10:   o_cnt_nxt_s = o_cnt_r + CNT_ONE;
      2'b01:   o_cnt_nxt_s = o_cnt_r - CNT_ONE;
      default: o_cnt_nxt_s = o_cnt_r;
    endcase
    q_left_s    = pop_s  ? (q_cnt_r - CNT_ONE) : q_cnt_r;
    q_cnt_nxt_s = push_s ? (q_left_s + CNT_ONE) : q_left_s;
    q_rd_nxt_s  = pop_s  ? (q_rd_r + PTR_ONE) : q_rd_r;
    if (push_s && (q_left_s == CNT_ZERO)) begin
      head_inst_s = imem_rsp_data_F;
      head_pc_s   = rsp_pc_s;
    end else begin
      head_inst_s = q_inst_r[q_rd_nxt_s];
      head_pc_s   = q_pc_r[q_rd_nxt_s];
    end
  end

  // Fetch PC, counters, pointers and registered decode-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_r        <= RESET_PC;
      q_rd_r       <= PTR_ZERO;
      q_wr_r       <= PTR_ZERO;
      o_rd_r       <= PTR_ZERO;
      o_wr_r       <= PTR_ZERO;
      q_cnt_r      <= CNT_ZERO;
      o_cnt_r      <= CNT_ZERO;
      disc_r       <= CNT_ZERO;
      inst_valid_D <= 1'b0;
      inst_D       <= '0;
      pc_D         <= '0;
    end else begin
      o_cnt_r <= o_cnt_nxt_s;
      if (issue_s) begin
        o_wr_r <= o_wr_r + PTR_ONE;
      end
      if (imem_rsp_valid_F) begin
        o_rd_r <= o_rd_r + PTR_ONE;
      end
      if (redirect_F) begin
        // Everything still in flight after this edge, including a same-cycle issue, is stale.
        fpc_r        <= redirect_addr_F & ALIGN_MASK;
        disc_r       <= o_cnt_nxt_s;
        q_cnt_r      <= CNT_ZERO;
        q_rd_r       <= PTR_ZERO;
        q_wr_r       <= PTR_ZERO;
        inst_valid_D <= 1'b0;
      end else begin
        if (issue_s) begin
          fpc_r <= fpc_r + STEP_V;
        end
        if (drop_s) begin
          disc_r <= disc_r - CNT_ONE;
        end
        if (push_s) begin
          q_wr_r <= q_wr_r + PTR_ONE;
        end
        q_cnt_r      <= q_cnt_nxt_s;
        q_rd_r       <= q_rd_nxt_s;
        inst_valid_D <= (q_cnt_nxt_s != CNT_ZERO);
        if (q_cnt_nxt_s != CNT_ZERO) begin
          inst_D <= head_inst_s;
          pc_D   <= head_pc_s;
        end
      end
    end
  end

  // Storage arrays for in-flight PCs and buffered instructions.
  always_ff @(posedge clk) begin
    if (issue_s) begin
      o_pc_r[o_wr_r] <= fpc_r;
    end
    if (push_s) begin
      q_inst_r[q_wr_r] <= imem_rsp_data_F;
      q_pc_r[q_wr_r]   <= rsp_pc_s;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: in-order memory model with configurable latency and
// an expected-PC tracker that checks every instruction accepted by decode.
module tb_fetch_prefetch;

  localparam int          ADDR_W   = 64;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam int          STEP     = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              redirect_F = 1'b0;
  logic [ADDR_W-1:0] redirect_addr_F = '0;
  logic              imem_req_valid_F;
  logic              imem_req_ready_F = 1'b0;
  logic [ADDR_W-1:0] imem_addr_F;
  logic              imem_rsp_valid_F = 1'b0;
  logic [INST_W-1:0] imem_rsp_data_F = '0;
  logic              inst_valid_D;
  logic              inst_ready_D = 1'b0;
  logic [INST_W-1:0] inst_D;
  logic [ADDR_W-1:0] pc_D;

  fetch_prefetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_F(redirect_F), .redirect_addr_F(redirect_addr_F),
    .imem_req_valid_F(imem_req_valid_F), .imem_req_ready_F(imem_req_ready_F),
    .imem_addr_F(imem_addr_F),
    .imem_rsp_valid_F(imem_rsp_valid_F), .imem_rsp_data_F(imem_rsp_data_F),
    .inst_valid_D(inst_valid_D), .inst_ready_D(inst_ready_D),
    .inst_D(inst_D), .pc_D(pc_D)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          accepts = 0;
  int          issues = 0;
  logic [63:0] exp_pc = 64'h0;
  logic [63:0] mq_addr[$];
  int          mq_due[$];
  bit          prev_pend = 1'b0;
  logic [63:0] prev_addr = 64'h0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: entered just after a falling edge, leaves after the next one.
  task automatic cycle(input logic req_rdy, input logic dec_rdy, input logic redir,
                       input logic [63:0] raddr);
    if (prev_pend) begin
      check_eq("req_hold_valid", 64'(imem_req_valid_F), 64'd1);
      check_eq("req_hold_addr", imem_addr_F, prev_addr);
    end
    imem_req_ready_F = req_rdy;
    inst_ready_D     = dec_rdy;
    redirect_F       = redir;
    redirect_addr_F  = raddr;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid_F = 1'b1;
      imem_rsp_data_F  = inst_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid_F = 1'b0;
      imem_rsp_data_F  = 32'h0;
    end
    if (inst_valid_D && dec_rdy && !redir) begin
      check_eq("pc_D", pc_D, exp_pc);
      check_eq("inst_D", 64'(inst_D), 64'(inst_of(exp_pc)));
      exp_pc = exp_pc + 64'd4;
      accepts++;
    end
    if (imem_req_valid_F && req_rdy) begin
      mq_addr.push_back(imem_addr_F);
      mq_due.push_back(cyc + lat);
      issues++;
    end
    prev_pend = imem_req_valid_F && !req_rdy && !redir;
    prev_addr = imem_addr_F;
    if (redir) exp_pc = raddr & ~64'h3;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset mid-cycle, then release on a falling edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_inst_valid", 64'(inst_valid_D), 64'd0);
    check_eq("rst_inst", 64'(inst_D), 64'd0);
    check_eq("rst_pc", pc_D, 64'd0);
    check_eq("rst_addr", imem_addr_F, RESET_PC);
    redirect_F = 1'b0;
    imem_req_ready_F = 1'b0;
    imem_rsp_valid_F = 1'b0;
    imem_rsp_data_F = 32'h0;
    inst_ready_D = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    prev_pend = 1'b0;
    exp_pc = RESET_PC;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("first_req_valid", 64'(imem_req_valid_F), 64'd1);
    check_eq("first_req_addr", imem_addr_F, RESET_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);

    // Streaming fill: one instruction per cycle after two fill cycles.
    lat = 1;
    do_reset();
    accepts = 0;
    check_eq("fill_c0", 64'(inst_valid_D), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("fill_c1", 64'(inst_valid_D), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 6; i++) begin
      check_eq("stream_valid", 64'(inst_valid_D), 64'd1);
      cycle(1'b1, 1'b1, 1'b0, 64'h0);
    end
    check_eq("stream_accepts", 64'(accepts), 64'd6);

    // Decode stall: credit caps issue at DEPTH requests.
    do_reset();
    issues = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 64'h0);
    check_eq("stall_issues", 64'(issues), 64'd4);
    check_eq("stall_req_low", 64'(imem_req_valid_F), 64'd0);
    accepts = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("stall_resume", 64'(accepts >= 8), 64'd1);

    // Redirect with requests in flight on a 3-cycle memory.
    lat = 3;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b1, 64'h1003);
    check_eq("redir_valid_low", 64'(inst_valid_D), 64'd0);
    check_eq("redir_addr", imem_addr_F, 64'h1000);
    accepts = 0;
    for (int i = 0; i < 40 && accepts < 2; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("redir_progress", 64'(accepts >= 2), 64'd1);

    // Address wrap at the top of the address space.
    cycle(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_target", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 10 && !imem_req_valid_F; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("wrap_addr", imem_addr_F, 64'h0);
    accepts = 0;
    for (int i = 0; i < 40 && accepts < 3; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("wrap_progress", 64'(accepts >= 3), 64'd1);

    // Random memory and decode backpressure on the 3-cycle memory.
    accepts = 0;
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 64'h0);
    check_eq("random_progress", 64'(accepts >= 20), 64'd1);

    // Reset in the middle of a stream.
    lat = 1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    do_reset();
    accepts = 0;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 64'h0);
    check_eq("post_rst_accepts", 64'(accepts), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
